// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings for the pipeline sequencing block.
//   fwd_e     operand source select (RF / EX / MEM / WB)
//   pc_sel_e  next-PC source select
//   state_e   hazard FSM states
//   COND_ALWAYS  Bicc cond field of ba
//   stage_hit helper: a stage's destination matches a source register
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_e;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_BR   = 2'b01,
    PC_RSVD = 2'b10,
    PC_HOLD = 2'b11
  } pc_sel_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  localparam logic [3:0] COND_ALWAYS = 4'b1000;

  // %g0 reads as zero and is never a forwarding source.
  function automatic logic stage_hit(input logic le, input logic [4:0] rd,
                                     input logic [4:0] rs);
    return le && (rd == rs) && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: combinational forwarding select for one ID source operand.
//   rs, use             source register and whether ID reads it
//   ex_/mem_/wb_ rd,le  destination and write enable per downstream stage
//   ex_load             EX holds a load (data not ready yet)
//   fwd                 operand source, EX > MEM > WB > register file
//   load_hit            this operand depends on the load in EX (load-use)
module hazard_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       use_rs,
  input  logic [4:0] ex_rd,
  input  logic       ex_rf_le,
  input  logic       ex_load,
  input  logic [4:0] mem_rd,
  input  logic       mem_rf_le,
  input  logic [4:0] wb_rd,
  input  logic       wb_rf_le,
  output logic [1:0] fwd,
  output logic       load_hit
);

  logic ex_hit, mem_hit, wb_hit;

  always_comb begin
    ex_hit   = stage_hit(ex_rf_le, ex_rd, rs);
    mem_hit  = stage_hit(mem_rf_le, mem_rd, rs);
    wb_hit   = stage_hit(wb_rf_le, wb_rd, rs);
    load_hit = use_rs && ex_load && ex_hit;
    // A load in EX has no data to forward; the stall covers that case, so
    // the EX match is skipped and older stages are still considered.
    if (ex_hit && !ex_load) fwd = FWD_EX;
    else if (mem_hit)       fwd = FWD_MEM;
    else if (wb_hit)        fwd = FWD_WB;
    else                    fwd = FWD_RF;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: sequencing for the 5-stage SPARC pipeline.
//   clk, clr (async, active-low)
//   id_rs1/id_rs2, id_use_rs1/id_use_rs2    ID source operands
//   ex_/mem_/wb_ rd, rf_le; ex_load          downstream destinations
//   id_branch, br_taken, br_annul, br_always ID branch resolution
//   pc_le, npc_le, if_id_le, pc_sel          front-end load enables / PC mux
//   if_id_clr                                annul delay slot in IF/ID
//   id_ex_nop                                inject bubble into ID/EX
//   fwd_a, fwd_b                             operand forwarding selects
//   stall_cnt, annul_cnt                     saturating event counters
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             ex_rf_le,
  input  logic             mem_rf_le,
  input  logic             wb_rf_le,
  input  logic             ex_load,
  input  logic             id_branch,
  input  logic             br_taken,
  input  logic             br_annul,
  input  logic             br_always,
  output logic             pc_le,
  output logic             npc_le,
  output logic             if_id_le,
  output logic [1:0]       pc_sel,
  output logic             if_id_clr,
  output logic             id_ex_nop,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] annul_cnt
);

  // First hazard cycle is spent in RUN, so STALL covers the remaining
  // LOAD_STALL_CYCLES-1 cycles, counting down to zero.
  localparam logic [2:0] CNT_INIT =
    (LOAD_STALL_CYCLES > 1) ? 3'(LOAD_STALL_CYCLES - 2) : 3'd0;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e     state, state_d;
  logic [2:0] cnt, cnt_d;
  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       hit_a, hit_b, hz, stall;

  hazard_fwd_unit u_fwd_a (
    .rs        (id_rs1),
    .use_rs    (id_use_rs1),
    .ex_rd     (ex_rd),
    .ex_rf_le  (ex_rf_le),
    .ex_load   (ex_load),
    .mem_rd    (mem_rd),
    .mem_rf_le (mem_rf_le),
    .wb_rd     (wb_rd),
    .wb_rf_le  (wb_rf_le),
    .fwd       (fwd_a_raw),
    .load_hit  (hit_a)
  );

  hazard_fwd_unit u_fwd_b (
    .rs        (id_rs2),
    .use_rs    (id_use_rs2),
    .ex_rd     (ex_rd),
    .ex_rf_le  (ex_rf_le),
    .ex_load   (ex_load),
    .mem_rd    (mem_rd),
    .mem_rf_le (mem_rf_le),
    .wb_rd     (wb_rd),
    .wb_rf_le  (wb_rf_le),
    .fwd       (fwd_b_raw),
    .load_hit  (hit_b)
  );

  assign hz = hit_a | hit_b;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= ST_RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    stall     = 1'b0;
    pc_le     = 1'b1;
    npc_le    = 1'b1;
    if_id_le  = 1'b1;
    pc_sel    = PC_SEQ;
    if_id_clr = 1'b0;
    id_ex_nop = 1'b0;
    fwd_a     = fwd_a_raw;
    fwd_b     = fwd_b_raw;

    case (state)
      ST_RUN: begin
        if (hz) begin
          stall = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = ST_STALL;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_STALL: begin
        stall = 1'b1;
        if (cnt == 3'd0) state_d = ST_RUN;
        else             cnt_d   = cnt - 3'd1;
      end
      default: state_d = ST_RUN;
    endcase

    if (stall) begin
      // Front end frozen: a branch in ID waits and resolves after the stall.
      pc_le     = 1'b0;
      npc_le    = 1'b0;
      if_id_le  = 1'b0;
      pc_sel    = PC_HOLD;
      id_ex_nop = 1'b1;
    end else if (id_branch) begin
      if (br_taken) pc_sel = PC_BR;
      // a=1 annuls the delay slot when untaken, and always for ba.
      if_id_clr = br_annul && (br_always || !br_taken);
    end

    // Reset holds the pipeline frozen with bubbles, independent of clk.
    if (!clr) begin
      pc_le     = 1'b0;
      npc_le    = 1'b0;
      if_id_le  = 1'b0;
      pc_sel    = PC_HOLD;
      if_id_clr = 1'b0;
      id_ex_nop = 1'b1;
      fwd_a     = FWD_RF;
      fwd_b     = FWD_RF;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      stall_cnt <= '0;
      annul_cnt <= '0;
    end else begin
      if (id_ex_nop && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_clr && annul_cnt != CNT_MAX) annul_cnt <= annul_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: dut1 (1 stall cycle, 16-bit counters) and dut3 (3 stall
// cycles, 4-bit counters so saturation is reachable quickly) share inputs.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic clr;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_rf_le, mem_rf_le, wb_rf_le, ex_load;
  logic id_branch, br_taken, br_annul, br_always;

  logic pc_le1, npc_le1, if_id_le1, if_id_clr1, id_ex_nop1;
  logic [1:0] pc_sel1, fwd_a1, fwd_b1;
  logic [15:0] stall_cnt1, annul_cnt1;
  logic pc_le3, npc_le3, if_id_le3, if_id_clr3, id_ex_nop3;
  logic [1:0] pc_sel3, fwd_a3, fwd_b3;
  logic [3:0] stall_cnt3, annul_cnt3;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .clr(clr), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_rf_le(ex_rf_le), .mem_rf_le(mem_rf_le),
    .wb_rf_le(wb_rf_le), .ex_load(ex_load), .id_branch(id_branch),
    .br_taken(br_taken), .br_annul(br_annul), .br_always(br_always),
    .pc_le(pc_le1), .npc_le(npc_le1), .if_id_le(if_id_le1), .pc_sel(pc_sel1),
    .if_id_clr(if_id_clr1), .id_ex_nop(id_ex_nop1), .fwd_a(fwd_a1),
    .fwd_b(fwd_b1), .stall_cnt(stall_cnt1), .annul_cnt(annul_cnt1)
  );

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) dut3 (
    .clk(clk), .clr(clr), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_rf_le(ex_rf_le), .mem_rf_le(mem_rf_le),
    .wb_rf_le(wb_rf_le), .ex_load(ex_load), .id_branch(id_branch),
    .br_taken(br_taken), .br_annul(br_annul), .br_always(br_always),
    .pc_le(pc_le3), .npc_le(npc_le3), .if_id_le(if_id_le3), .pc_sel(pc_sel3),
    .if_id_clr(if_id_clr3), .id_ex_nop(id_ex_nop3), .fwd_a(fwd_a3),
    .fwd_b(fwd_b3), .stall_cnt(stall_cnt3), .annul_cnt(annul_cnt3)
  );

  // Output bundle: {pc_le, npc_le, if_id_le, pc_sel, if_id_clr, id_ex_nop, fwd_a, fwd_b}
  logic [11:0] o1, o3;
  assign o1 = {pc_le1, npc_le1, if_id_le1, pc_sel1, if_id_clr1, id_ex_nop1, fwd_a1, fwd_b1};
  assign o3 = {pc_le3, npc_le3, if_id_le3, pc_sel3, if_id_clr3, id_ex_nop3, fwd_a3, fwd_b3};

  localparam logic [11:0] O_RUN   = 12'b111_00_0_0_00_00;
  localparam logic [11:0] O_STALL = 12'b000_11_0_1_00_00;

  typedef struct packed {
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  exrd, memrd, wbrd;
    logic [2:0]  le;   // {ex, mem, wb}
    logic        ld;
    logic [3:0]  br;   // {branch, taken, annul, always}
    logic [11:0] exp;
  } vec_t;

  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic [4:0] exrd, logic [4:0] memrd, logic [4:0] wbrd,
                              logic [2:0] le, logic ld, logic [3:0] br, logic [11:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.exrd = exrd; v.memrd = memrd; v.wbrd = wbrd;
    v.le = le; v.ld = ld; v.br = br; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    ex_rd = v.exrd; mem_rd = v.memrd; wb_rd = v.wbrd;
    {ex_rf_le, mem_rf_le, wb_rf_le} = v.le;
    ex_load = v.ld;
    {id_branch, br_taken, br_annul, br_always} = v.br;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  vec_t vt[17];
  vec_t idle, hz_v, annul_v, brhz_v;
  logic [5:0] pat;

  initial begin
    // Expected bundles worked out by hand from the operation rules.
    vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 4'b0000, 12'b111_00_0_0_00_00); // idle
    vt[1]  = mk(5, 0, 1, 0, 5, 0, 0, 3'b100, 1, 4'b0000, 12'b000_11_0_1_00_00); // load-use rs1
    vt[2]  = mk(5, 0, 0, 0, 5, 0, 0, 3'b100, 1, 4'b0000, 12'b111_00_0_0_00_00); // rs1 unused
    vt[3]  = mk(0, 0, 1, 0, 0, 0, 0, 3'b100, 1, 4'b0000, 12'b111_00_0_0_00_00); // load to g0
    vt[4]  = mk(0, 7, 0, 1, 7, 7, 0, 3'b110, 0, 4'b0000, 12'b111_00_0_0_00_01); // EX over MEM
    vt[5]  = mk(0, 7, 0, 1, 0, 7, 0, 3'b010, 0, 4'b0000, 12'b111_00_0_0_00_10); // MEM
    vt[6]  = mk(0, 7, 0, 1, 0, 0, 7, 3'b001, 0, 4'b0000, 12'b111_00_0_0_00_11); // WB only
    vt[7]  = mk(0, 0, 0, 1, 0, 0, 0, 3'b111, 0, 4'b0000, 12'b111_00_0_0_00_00); // rd=0
    vt[8]  = mk(0, 7, 0, 1, 7, 7, 0, 3'b010, 0, 4'b0000, 12'b111_00_0_0_00_10); // EX not writing
    vt[9]  = mk(0, 7, 0, 0, 7, 7, 0, 3'b110, 1, 4'b0000, 12'b111_00_0_0_00_10); // EX load skipped
    vt[10] = mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 4'b1010, 12'b111_00_1_0_00_00); // bne,a untaken
    vt[11] = mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 4'b1111, 12'b111_01_1_0_00_00); // ba,a
    vt[12] = mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 4'b1110, 12'b111_01_0_0_00_00); // be,a taken
    vt[13] = mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 4'b1000, 12'b111_00_0_0_00_00); // bne untaken
    vt[14] = mk(5, 0, 1, 0, 5, 0, 0, 3'b100, 1, 4'b1010, 12'b000_11_0_1_00_00); // branch + load-use
    vt[15] = mk(3, 4, 1, 1, 4, 0, 3, 3'b101, 0, 4'b0000, 12'b111_00_0_0_11_01); // WB a, EX b
    vt[16] = mk(4, 9, 1, 1, 9, 4, 0, 3'b110, 1, 4'b0000, 12'b000_11_0_1_10_00); // load-use rs2
    idle    = vt[0];
    hz_v    = vt[1];
    annul_v = vt[10];
    brhz_v  = vt[14];

    // Reset forces outputs even with forwarding inputs present.
    clr = 1'b0;
    apply(vt[15]);
    #3;
    chk("reset_outputs", 32'(o1), 32'(O_STALL));
    #4;
    chk("reset_stall_cnt", 32'(stall_cnt1), 0);
    chk("reset_annul_cnt", 32'(annul_cnt1), 0);
    @(negedge clk);
    clr = 1'b1;

    // Combinational vectors on dut1 (never leaves RUN).
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      apply(vt[i]);
      #1;
      chk($sformatf("vec%0d", i), 32'(o1), 32'(vt[i].exp));
    end

    // Re-reset so both instances start from RUN with zero counters.
    @(negedge clk);
    clr = 1'b0;
    apply(idle);
    @(negedge clk);
    clr = 1'b1;

    // One load-use event: dut1 stalls 1 cycle, dut3 exactly 3.
    apply(hz_v);
    pat = '0;
    for (int k = 0; k < 6; k++) begin
      #1;
      pat[k] = id_ex_nop3;
      if (k == 0) chk("lsc1_stall", 32'(o1), 32'(O_STALL));
      if (k == 1) begin
        chk("lsc1_resume", 32'(pc_le1), 1);
        chk("lsc1_stall_cnt", 32'(stall_cnt1), 1);
      end
      @(negedge clk);
      apply(idle);
    end
    chk("lsc3_pattern", 32'(pat), 32'(6'b000111));
    chk("lsc3_stall_cnt", 32'(stall_cnt3), 3);
    chk("lsc3_run_outputs", 32'(o3), 32'(O_RUN));

    // Load-use coincident with an annulling branch: stall first, then annul.
    apply(brhz_v);
    #1;
    chk("brhz_stall", 32'(o1), 32'(O_STALL));
    @(negedge clk);
    apply(annul_v);
    #1;
    chk("brhz_resolve", 32'(o1), 32'(12'b111_00_1_0_00_00));
    chk("brhz_dut3_noannul", 32'(if_id_clr3), 0);
    @(negedge clk);
    apply(idle);
    #1;
    chk("brhz_annul_cnt", 32'(annul_cnt1), 1);
    chk("brhz_stall_cnt", 32'(stall_cnt1), 2);
    repeat (3) @(negedge clk);

    // Reset asserted while dut3 is in STALL.
    apply(hz_v);
    @(negedge clk);
    apply(idle);
    #1;
    chk("midstall_before", 32'(id_ex_nop3), 1);
    clr = 1'b0;
    #1;
    chk("midstall_forced", 32'(o3), 32'(O_STALL));
    chk("midstall_cnt_clr", 32'(stall_cnt3), 0);
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("midstall_release", 32'(o3), 32'(O_RUN));

    // Hold an annulling branch for 20 cycles: dut3 counter saturates.
    @(negedge clk);
    apply(annul_v);
    repeat (20) @(negedge clk);
    #1;
    chk("annul_sat", 32'(annul_cnt3), 32'h0000000F);
    chk("annul_count20", 32'(annul_cnt1), 20);
    @(negedge clk);
    #1;
    chk("annul_sat_hold", 32'(annul_cnt3), 32'h0000000F);
    apply(idle);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
